// File: rtl/decimal_entry_if.sv
// Handshake bundle between the options-menu input FSM and the decimal entry encoder.
// master = the key-entry source, slave = the encoder.
interface decimal_entry_if #(
    parameter int W_OUT  = 8,
    parameter int DIGITS = 2
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                   start;
    logic                   digit_valid;
    logic [3:0]             digit;
    logic                   digit_ready;
    logic                   backspace;
    logic                   commit;
    logic                   cancel;
    logic [DIGITS-1:0][3:0] entry_digits;
    logic [CW-1:0]          entry_count;
    logic                   busy;
    logic                   digit_error;
    logic [W_OUT-1:0]       value_out;
    logic                   value_valid;

    modport master (
        output start, digit_valid, digit, backspace, commit, cancel,
        input  digit_ready, entry_digits, entry_count, busy, digit_error,
               value_out, value_valid
    );

    modport slave (
        input  start, digit_valid, digit, backspace, commit, cancel,
        output digit_ready, entry_digits, entry_count, busy, digit_error,
               value_out, value_valid
    );
endinterface

// File: rtl/decimal_entry_encoder.sv
// Collects typed decimal digits, converts them to binary with a one-digit-per-cycle
// multiply-accumulate, clamps to [MIN_VAL, MAX_VAL] and strobes the result.
module decimal_entry_encoder #(
    parameter int W_OUT   = 8,
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 1,
    parameter int MAX_VAL = 99
) (
    input logic            clk,
    input logic            nreset,
    decimal_entry_if.slave bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int AW = W_OUT + 4;

    typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, DONE} state_t;

    state_t                 state;
    logic [DIGITS-1:0][3:0] digits;
    logic [DIGITS-1:0][3:0] shift_up;
    logic [DIGITS-1:0][3:0] shift_dn;
    logic [CW-1:0]          count;
    logic [CW-1:0]          idx;
    logic [3:0]             cur_digit;
    logic [AW-1:0]          acc;
    logic [W_OUT-1:0]       value;
    logic                   value_valid;
    logic                   digit_error;

    function automatic logic [W_OUT-1:0] clamp(input logic [AW-1:0] a);
        if (a < AW'(MIN_VAL))
            clamp = W_OUT'(MIN_VAL);
        else if (a > AW'(MAX_VAL))
            clamp = W_OUT'(MAX_VAL);
        else
            clamp = a[W_OUT-1:0];
    endfunction

    // [0] always holds the newest digit, so typing pushes up and backspace pulls down
    always_comb begin
        shift_up  = digits;
        shift_dn  = digits;
        cur_digit = 4'd0;
        for (int i = DIGITS - 1; i > 0; i--) shift_up[i] = digits[i-1];
        shift_up[0] = bus.digit;
        for (int i = 0; i < DIGITS - 1; i++) shift_dn[i] = digits[i+1];
        shift_dn[DIGITS-1] = 4'd0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == CW'(i)) cur_digit = digits[i];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            digits      <= '0;
            count       <= '0;
            idx         <= '0;
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            digit_error <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            digit_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ENTRY;
                        digits <= '0;
                        count  <= '0;
                    end
                end
                ENTRY: begin
                    if (bus.cancel) begin
                        state  <= IDLE;
                        digits <= '0;
                        count  <= '0;
                    end else if (bus.commit) begin
                        state <= CONVERT;
                        idx   <= count - CW'(1);
                        acc   <= '0;
                    end else if (bus.backspace) begin
                        if (count != '0) begin
                            digits <= shift_dn;
                            count  <= count - CW'(1);
                        end
                    end else if (bus.digit_valid && bus.digit_ready) begin
                        if (bus.digit <= 4'd9) begin
                            digits <= shift_up;
                            count  <= count + CW'(1);
                        end else begin
                            digit_error <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    // Oldest digit first; an empty entry spends one cycle and leaves acc at 0
                    if (bus.cancel) begin
                        state  <= IDLE;
                        digits <= '0;
                        count  <= '0;
                    end else if (count == '0) begin
                        state <= DONE;
                    end else begin
                        acc <= (acc << 3) + (acc << 1) + AW'(cur_digit);
                        idx <= idx - CW'(1);
                        if (idx == '0) state <= DONE;
                    end
                end
                DONE: begin
                    value       <= clamp(acc);
                    value_valid <= 1'b1;
                    digits      <= '0;
                    count       <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.digit_ready  = (state == ENTRY) && (count < CW'(DIGITS));
    assign bus.entry_digits = digits;
    assign bus.entry_count  = count;
    assign bus.busy         = (state != IDLE);
    assign bus.digit_error  = digit_error;
    assign bus.value_out    = value;
    assign bus.value_valid  = value_valid;
endmodule

// File: tb/tb_decimal_entry_encoder.sv
// Bench for decimal_entry_encoder: a 2-digit and a 3-digit instance share one stimulus
// stream and are each compared every cycle against a digit-list reference model.
module tb_decimal_entry_encoder;
    logic       clk;
    logic       nreset;
    logic       start, digit_valid, backspace, commit, cancel;
    logic [3:0] digit;

    int n_checks = 0;
    int n_errors = 0;

    decimal_entry_if #(.W_OUT(8), .DIGITS(2)) if0 ();
    decimal_entry_if #(.W_OUT(8), .DIGITS(3)) if1 ();

    decimal_entry_encoder #(.W_OUT(8), .DIGITS(2), .MIN_VAL(1), .MAX_VAL(99)) dut0 (
        .clk(clk), .nreset(nreset), .bus(if0));
    decimal_entry_encoder #(.W_OUT(8), .DIGITS(3), .MIN_VAL(1), .MAX_VAL(99)) dut1 (
        .clk(clk), .nreset(nreset), .bus(if1));

    assign if0.start = start;       assign if1.start = start;
    assign if0.digit_valid = digit_valid; assign if1.digit_valid = digit_valid;
    assign if0.digit = digit;       assign if1.digit = digit;
    assign if0.backspace = backspace; assign if1.backspace = backspace;
    assign if0.commit = commit;     assign if1.commit = commit;
    assign if0.cancel = cancel;     assign if1.cancel = cancel;

    logic [31:0] o_dig [2];
    logic [31:0] o_cnt [2];
    logic [31:0] o_vo  [2];
    logic        o_busy[2], o_rdy[2], o_err[2], o_vv[2];

    assign o_dig[0] = 32'(if0.entry_digits); assign o_dig[1] = 32'(if1.entry_digits);
    assign o_cnt[0] = 32'(if0.entry_count);  assign o_cnt[1] = 32'(if1.entry_count);
    assign o_vo[0]  = 32'(if0.value_out);    assign o_vo[1]  = 32'(if1.value_out);
    assign o_busy[0] = if0.busy;        assign o_busy[1] = if1.busy;
    assign o_rdy[0]  = if0.digit_ready; assign o_rdy[1]  = if1.digit_ready;
    assign o_err[0]  = if0.digit_error; assign o_err[1]  = if1.digit_error;
    assign o_vv[0]   = if0.value_valid; assign o_vv[1]   = if1.value_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: typed digits kept oldest-first, plus a countdown to the result strobe
    int cap [2] = '{2, 3};
    bit sess [2];
    int rem  [2];
    int qn   [2];
    int qd   [2][4];
    int m_vo [2];
    bit m_err[2];
    bit m_vv [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seq_value(input int k);
        int v = 0;
        for (int i = 0; i < qn[k]; i++) v += qd[k][i] * (10 ** (qn[k] - 1 - i));
        return v;
    endfunction

    function automatic int clamp_ref(input int v);
        if (v < 1) return 1;
        if (v > 99) return 99;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sess[k] = 0; rem[k] = 0; qn[k] = 0; m_vo[k] = 0; m_err[k] = 0; m_vv[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int n;
        n = qn[k];
        m_err[k] = 0;
        m_vv[k]  = 0;
        if (rem[k] > 0) begin
            if (rem[k] > 1 && cancel) begin
                rem[k] = 0; qn[k] = 0;
            end else begin
                rem[k]--;
                if (rem[k] == 0) begin
                    m_vo[k] = clamp_ref(seq_value(k));
                    m_vv[k] = 1;
                    qn[k]   = 0;
                end
            end
        end else if (sess[k]) begin
            if (cancel) begin
                sess[k] = 0; qn[k] = 0;
            end else if (commit) begin
                sess[k] = 0;
                rem[k]  = ((n > 1) ? n : 1) + 1;
            end else if (backspace) begin
                if (n > 0) qn[k] = n - 1;
            end else if (digit_valid && n < cap[k]) begin
                if (digit <= 4'd9) begin
                    qd[k][n] = int'(digit);
                    qn[k]    = n + 1;
                end else begin
                    m_err[k] = 1;
                end
            end
        end else if (start) begin
            sess[k] = 1; qn[k] = 0;
        end
    endtask

    task automatic compare(input int k);
        logic [31:0] e_dig;
        e_dig = '0;
        for (int i = 0; i < qn[k]; i++) e_dig[i*4 +: 4] = 4'(qd[k][qn[k] - 1 - i]);
        check_eq($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(sess[k] || rem[k] > 0));
        check_eq($sformatf("ready%0d", k), 32'(o_rdy[k]), 32'(sess[k] && qn[k] < cap[k]));
        check_eq($sformatf("count%0d", k), o_cnt[k], 32'(qn[k]));
        check_eq($sformatf("digits%0d", k), o_dig[k], e_dig);
        check_eq($sformatf("derr%0d", k), 32'(o_err[k]), 32'(m_err[k]));
        check_eq($sformatf("vvalid%0d", k), 32'(o_vv[k]), 32'(m_vv[k]));
        check_eq($sformatf("vout%0d", k), o_vo[k], 32'(m_vo[k]));
    endtask

    task automatic clear_inputs();
        start = 0; digit_valid = 0; digit = 4'd0; backspace = 0; commit = 0; cancel = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare(0);
        compare(1);
        clear_inputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int d);
        digit_valid = 1;
        digit = 4'(d);
        tick();
    endtask

    task automatic do_start();
        start = 1;
        tick();
    endtask

    task automatic do_commit();
        commit = 1;
        tick();
    endtask

    // Asynchronous reset asserted between clock edges, released on the next falling edge
    task automatic async_reset(input string tag);
        nreset = 0;
        #1;
        model_reset();
        check_eq({tag, "_busy"}, 32'(o_busy[0]), 32'd0);
        check_eq({tag, "_vout"}, o_vo[0], 32'd0);
        check_eq({tag, "_vvalid"}, 32'(o_vv[0]), 32'd0);
        check_eq({tag, "_digits"}, o_dig[0], 32'd0);
        check_eq({tag, "_count"}, o_cnt[0], 32'd0);
        check_eq({tag, "_ready"}, 32'(o_rdy[0]), 32'd0);
        compare(0);
        compare(1);
        @(negedge clk);
        nreset = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        nreset = 0;
        #3;
        async_reset("por");

        // 4,2 -> 42 with a single-cycle strobe three cycles after commit
        do_start(); press(4); press(2); do_commit();
        ticks(2);
        check_eq("t42_early", 32'(o_vv[0]), 32'd0);
        tick();
        check_eq("t42_vvalid", 32'(o_vv[0]), 32'd1);
        check_eq("t42_val", o_vo[0], 32'd42);
        tick();
        check_eq("t42_pulse_end", 32'(o_vv[0]), 32'd0);

        // 0,0 clamps up to MIN_VAL
        do_start(); press(0); press(0); do_commit(); ticks(3);
        check_eq("t00_val", o_vo[0], 32'd1);

        // 1,5,0: 2-digit unit keeps 15, 3-digit unit clamps 150 to 99
        do_start(); press(1); press(5); press(0); do_commit(); ticks(4);
        check_eq("t150_d2", o_vo[0], 32'd15);
        check_eq("t150_d3", o_vo[1], 32'd99);

        // Third digit refused when full
        do_start(); press(7); press(3);
        digit_valid = 1; digit = 4'd5;
        #1 check_eq("t735_ready", 32'(o_rdy[0]), 32'd0);
        tick();
        check_eq("t735_digits", o_dig[0], 32'h73);
        do_commit(); ticks(3);
        check_eq("t735_val", o_vo[0], 32'd73);

        // Backspace, illegal digit, and a digit lost to a same-cycle commit
        do_start(); press(9); backspace = 1; tick(); press(5); press(12);
        check_eq("terr_pulse", 32'(o_err[0]), 32'd1);
        commit = 1; digit_valid = 1; digit = 4'd6; tick();
        ticks(2);
        check_eq("terr_val", o_vo[0], 32'd5);

        // Cancel keeps the previous value; empty commit yields MIN_VAL after two cycles
        do_start(); press(8); cancel = 1; tick();
        check_eq("tcan_busy", 32'(o_busy[0]), 32'd0);
        ticks(3);
        check_eq("tcan_hold", o_vo[0], 32'd5);
        do_start(); do_commit(); tick();
        check_eq("tempty_early", 32'(o_vv[0]), 32'd0);
        tick();
        check_eq("tempty_vvalid", 32'(o_vv[0]), 32'd1);
        check_eq("tempty_val", o_vo[0], 32'd1);

        // Reset mid-conversion, then start on the first edge after release
        do_start(); press(4); press(2); do_commit(); tick();
        async_reset("rmid");
        do_start();
        check_eq("rmid_restart", 32'(o_busy[0]), 32'd1);
        ticks(3);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 4) begin
                async_reset("rrnd");
            end else begin
                start       = ($urandom_range(0, 99) < 25);
                digit_valid = ($urandom_range(0, 99) < 60);
                digit       = 4'($urandom_range(0, 11));
                backspace   = ($urandom_range(0, 99) < 10);
                commit      = ($urandom_range(0, 99) < 8);
                cancel      = ($urandom_range(0, 99) < 3);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
